// File: rtl/sipo_serial_in.sv
// Serial-in/parallel-out reader for a chain of 74HC165-style shift registers.
// Repeats LOAD -> SHIFT -> DONE frames forever, publishing each word with a one-cycle valid.
module sipo_serial_in #(
   parameter int WIDTH   = 16,
   parameter int CLK_DIV = 10
) (
   input  logic             i_clk,
   input  logic             i_aclr_n,
   input  logic             i_sync,
   output logic             o_load_n,
   output logic             o_sclk,
   input  logic             i_sdi,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [DIV_W-1:0] DIV_SMPL = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [DIV_W-1:0]   r_div_cnt;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [WIDTH-1:0]   r_sr;
   logic               r_load_n;
   logic               r_sclk;
   logic [WIDTH-1:0]   r_data;
   logic               r_valid;

   state_t             w_state_next;
   logic [DIV_W-1:0]   w_div_next;
   logic [BIT_W-1:0]   w_bit_next;
   logic               w_load_n_next;
   logic               w_sclk_next;
   logic               w_valid_next;
   logic               w_sample;

   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div_cnt;
      w_bit_next   = r_bit_cnt;
      case (r_state)
         IDLE: begin
            w_state_next = LOAD;
            w_div_next   = '0;
            w_bit_next   = '0;
         end
         LOAD: begin
            if (r_div_cnt == DIV_LAST) begin
               w_state_next = SHIFT;
               w_div_next   = '0;
            end else begin
               w_div_next = r_div_cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (r_div_cnt == DIV_LAST) begin
               w_div_next = '0;
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_next = DONE;
                  w_bit_next   = '0;
               end else begin
                  w_bit_next = r_bit_cnt + 1'b1;
               end
            end else begin
               w_div_next = r_div_cnt + 1'b1;
            end
         end
         DONE: begin
            w_state_next = LOAD;
            w_div_next   = '0;
            w_bit_next   = '0;
         end
         default: begin
            w_state_next = IDLE;
            w_div_next   = '0;
            w_bit_next   = '0;
         end
      endcase

      // A restart request overrides whatever the frame was doing.
      if (i_sync) begin
         w_state_next = LOAD;
         w_div_next   = '0;
         w_bit_next   = '0;
      end

      // Outputs are derived from the next state so they line up with the state register.
      w_load_n_next = (w_state_next != LOAD);
      w_sclk_next   = (w_state_next == SHIFT) && (w_div_next >= DIV_HALF);
      w_valid_next  = (w_state_next == DONE);
      w_sample      = (r_state == SHIFT) && (r_div_cnt == DIV_SMPL);
   end

   always_ff @(posedge i_clk) begin
      if (!i_aclr_n) begin
         r_state   <= IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_sr      <= '0;
         r_load_n  <= 1'b1;
         r_sclk    <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_div_cnt <= w_div_next;
         r_bit_cnt <= w_bit_next;
         r_load_n  <= w_load_n_next;
         r_sclk    <= w_sclk_next;
         r_valid   <= w_valid_next;
         if (w_sample)
            r_sr <= {r_sr[WIDTH-2:0], i_sdi};
         if (w_valid_next)
            r_data <= r_sr;
      end
   end

   assign o_load_n = r_load_n;
   assign o_sclk   = r_sclk;
   assign o_data   = r_data;
   assign o_valid  = r_valid;

endmodule

// File: tb/tb_sipo_serial_in.sv
// Bench for sipo_serial_in: two chained 74HC165 models feed the reader; words are
// queued when loaded into the chain and popped when valid is seen.
module tb_sipo_serial_in;

   localparam int WIDTH     = 16;
   localparam int CLK_DIV   = 10;
   localparam int FRAME_LEN = CLK_DIV + WIDTH * CLK_DIV + 1;

   logic             clk = 1'b0;
   logic             i_aclr_n = 1'b0;
   logic             i_sync = 1'b0;
   logic             o_load_n;
   logic             o_sclk;
   logic             i_sdi;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;

   logic [15:0] pdata = 16'h0000;
   logic [15:0] chain = 16'h0000;
   logic        sclk_q = 1'b0;

   logic [15:0] exp_q[$];
   logic [15:0] last_data = 16'h0000;
   int          cyc = 0;
   int          last_valid = 0;
   bit          have_last = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_frame = 0;

   sipo_serial_in #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
      .i_clk    (clk),
      .i_aclr_n (i_aclr_n),
      .i_sync   (i_sync),
      .o_load_n (o_load_n),
      .o_sclk   (o_sclk),
      .i_sdi    (i_sdi),
      .o_data   (o_data),
      .o_valid  (o_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Chain of two 8-bit parts: upper byte sits nearest sdi, so sdi is bit 15.
   always @(negedge clk) begin
      if (!o_load_n)
         chain <= pdata;
      else if (o_sclk && !sclk_q)
         chain <= {chain[14:0], 1'b0};
      sclk_q <= o_sclk;
   end
   assign i_sdi = chain[15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_load_n"}, 32'(o_load_n), 32'd1);
      chk({tag, "_sclk"},   32'(o_sclk),   32'd0);
      chk({tag, "_data"},   32'(o_data),   32'd0);
      chk({tag, "_valid"},  32'(o_valid),  32'd0);
   endtask

   task automatic wait_load(input string tag, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (!o_load_n) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   // Entered at a falling edge while load_n is low; returns in the next LOAD.
   task automatic run_frame(input logic [15:0] word, input bit chk_period);
      logic [15:0] exp;
      int          rises;
      int          last_rise;
      bit          got;
      bit          prev_sclk;
      pdata = word;
      exp_q.push_back(word);
      rises = 0;
      last_rise = -1;
      got = 1'b0;
      prev_sclk = o_sclk;
      for (int i = 0; i < FRAME_LEN + 20 && !got; i++) begin
         @(negedge clk);
         if (o_sclk && !prev_sclk) begin
            if (last_rise >= 0) chk("sclk_period", 32'(cyc - last_rise), 32'(CLK_DIV));
            last_rise = cyc;
            rises++;
         end
         prev_sclk = o_sclk;
         if (!o_load_n) chk("sclk_low_in_load", 32'(o_sclk), 32'd0);
         if (o_valid) begin
            got = 1'b1;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk("data", 32'(o_data), 32'(exp));
            chk("sclk_rises", 32'(rises), 32'(WIDTH));
            if (chk_period && have_last)
               chk("valid_period", 32'(cyc - last_valid), 32'(FRAME_LEN));
            last_valid = cyc;
            have_last = 1'b1;
            last_data = exp;
            n_frame++;
            $display("frame %0d: data=%h expected=%h sclk_rises=%0d", n_frame, o_data, exp, rises);
         end else begin
            chk("data_hold", 32'(o_data), 32'(last_data));
         end
      end
      if (!got) chk("valid_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("valid_one_cycle", 32'(o_valid), 32'd0);
      chk("load_after_done", 32'(o_load_n), 32'd0);
   endtask

   initial begin
      // Reset held for 10 clocks
      i_aclr_n = 1'b0;
      repeat (10) @(negedge clk);
      chk_reset_outputs("reset");
      i_aclr_n = 1'b1;
      wait_load("load_after_reset", 2);

      run_frame(16'h1234, 1'b0);
      run_frame(16'h55AA, 1'b1);
      run_frame(16'h0000, 1'b1);
      run_frame(16'hFFFF, 1'b1);
      run_frame(16'h8001, 1'b1);

      // One-cycle sync in the middle of SHIFT aborts the frame.
      pdata = 16'hDEAD;
      for (int i = 0; i < CLK_DIV + 55; i++) begin
         @(negedge clk);
         chk("abort_valid", 32'(o_valid), 32'd0);
         chk("abort_data_hold", 32'(o_data), 32'(last_data));
      end
      i_sync = 1'b1;
      @(negedge clk);
      i_sync = 1'b0;
      chk("sync_reload", 32'(o_load_n), 32'd0);
      chk("sync_sclk", 32'(o_sclk), 32'd0);
      chk("sync_valid", 32'(o_valid), 32'd0);
      chk("sync_data_hold", 32'(o_data), 32'(last_data));
      $display("sync: frame aborted, data=%h", o_data);
      have_last = 1'b0;
      run_frame(16'h0F0F, 1'b0);
      run_frame(16'hA5C3, 1'b1);

      // Reset in the middle of SHIFT
      pdata = 16'hBEEF;
      repeat (CLK_DIV + 60) @(negedge clk);
      i_aclr_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset");
      last_data = 16'h0000;
      repeat (3) @(negedge clk);
      chk_reset_outputs("midreset_hold");
      $display("reset: outputs load_n=%b sclk=%b data=%h valid=%b", o_load_n, o_sclk, o_data, o_valid);
      i_aclr_n = 1'b1;
      have_last = 1'b0;
      wait_load("load_after_midreset", 2);
      run_frame(16'h3C96, 1'b0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
